// File: rtl/tdpram_master_pkg.sv
// Shared types and constants for the TDPRAM port master and its read buffer.
package tdpram_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_e;

    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned PTR_W     = $clog2(BUF_DEPTH);
    localparam int unsigned OCC_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/tdpram_rd_skid.sv
// Two-entry synchronous FIFO carrying {last, data} from the RAM read port to
// the client; the head entry is presented combinationally.
module tdpram_rd_skid
    import tdpram_master_pkg::*;
#(
    parameter int unsigned W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic             valid,
    output logic [OCC_W-1:0] occ
);

    logic [W-1:0]     mem_q [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] occ_q;
    logic             do_push;
    logic             do_pop;

    assign valid   = (occ_q != '0);
    assign do_pop  = pop && valid;
    assign do_push = push && ((occ_q != OCC_W'(BUF_DEPTH)) || do_pop);
    assign head    = mem_q[rd_ptr_q];
    assign occ     = occ_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            occ_q <= occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
        end
    end

endmodule

// File: rtl/tdpram_port_master.sv
// Command-driven initiator for one TDPRAM port: write bursts pass straight to
// the RAM pins, read bursts are issued with flow control into a 2-entry buffer.
module tdpram_port_master
    import tdpram_master_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 8,
    parameter int unsigned LW    = 8,
    parameter int unsigned U_DLY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic          wd_valid,
    output logic          wd_ready,
    input  logic [DW-1:0] wd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          ram_wr,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);

    localparam int unsigned HW = OCC_W + 1;

    state_e           state_q;
    state_e           state_d;
    logic [AW-1:0]    addr_q;
    logic [AW-1:0]    addr_d;
    logic [LW-1:0]    cnt_q;
    logic [LW-1:0]    cnt_d;
    logic             pend_q;
    logic             pend_last_q;
    logic             issue;
    logic             issue_last;
    logic             pop;
    logic             can_issue;
    logic [HW-1:0]    held_after;
    logic [OCC_W-1:0] occ;
    logic [DW:0]      head;
    logic             unused_dly;

    // Simulation-only update delay has no meaning in this delay-free RTL.
    assign unused_dly = (U_DLY != 0);

    assign pop        = rd_valid && rd_ready;
    // Beats held after this cycle's pop must leave room for one more issue.
    assign held_after = HW'(occ) + HW'(pend_q) - HW'(pop);
    assign can_issue  = (held_after < HW'(BUF_DEPTH));
    assign ram_addr   = addr_q;
    assign rd_data    = head[DW-1:0];
    assign rd_last    = head[DW];
    assign busy       = (state_q != ST_IDLE) || (occ != '0) || pend_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            pend_q      <= issue;
            pend_last_q <= issue_last;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        cmd_ready  = 1'b0;
        wd_ready   = 1'b0;
        ram_wr     = 1'b0;
        ram_wdata  = '0;
        issue      = 1'b0;
        issue_last = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid && cmd_ready) begin
                    addr_d  = cmd_addr;
                    cnt_d   = cmd_len;
                    state_d = cmd_wr ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                wd_ready  = 1'b1;
                ram_wr    = wd_valid;
                ram_wdata = wd_data;
                if (wd_valid) begin
                    addr_d = addr_q + AW'(1);
                    cnt_d  = cnt_q - LW'(1);
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_READ: begin
                if (can_issue) begin
                    issue  = 1'b1;
                    addr_d = addr_q + AW'(1);
                    cnt_d  = cnt_q - LW'(1);
                    if (cnt_q == '0) begin
                        issue_last = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    tdpram_rd_skid #(
        .W (DW + 1)
    ) u_rd_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (pend_q),
        .push_data ({pend_last_q, ram_rdata}),
        .pop       (pop),
        .head      (head),
        .valid     (rd_valid),
        .occ       (occ)
    );

endmodule

// File: tb/tb_tdpram_port_master.sv
// Randomized self-checking bench for tdpram_port_master with a behavioural RAM
// and a memory-image reference model.
`timescale 1ns/1ps
module tb_tdpram_port_master;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;
    localparam int unsigned LW = 8;
    localparam int HOLD_MAX = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_wr = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          wd_valid = 1'b0;
    logic          wd_ready;
    logic [DW-1:0] wd_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          ram_wr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          busy;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] ram_mem [1 << AW];
    logic [DW-1:0] ref_mem [1 << AW];
    logic [DW-1:0] wbuf    [1 << LW];
    logic          stall_pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    tdpram_port_master #(
        .DW    (DW),
        .AW    (AW),
        .LW    (LW),
        .U_DLY (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wd_valid  (wd_valid),
        .wd_ready  (wd_ready),
        .wd_data   (wd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .ram_wr    (ram_wr),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_wr) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic fill_wbuf_random();
        for (int i = 0; i < (1 << LW); i++) wbuf[i] = DW'($urandom);
    endtask

    // Write burst; mode 0 continuous, 1 stall pattern, 2 random wd_valid.
    task automatic run_write(input logic [AW-1:0] a, input logic [LW-1:0] l,
                             input int mode, input string tag);
        int n, sent, c;
        logic v;
        logic [AW-1:0] exp_addr;
        n = int'(l) + 1; sent = 0; c = 0; exp_addr = a;
        while (sent < n && c < 4 * n + 40) begin
            @(negedge clk);
            cmd_valid = (c == 0); cmd_wr = 1'b1; cmd_addr = a; cmd_len = l; rd_ready = 1'b0;
            if (c == 0) v = 1'b0;
            else if (mode == 0) v = 1'b1;
            else if (mode == 1) v = stall_pat[(c - 1) % 5];
            else v = 1'($urandom_range(0, 1));
            wd_valid = v; wd_data = wbuf[sent];
            #1;
            total++;
            if (c == 0) begin
                if (cmd_ready !== 1'b1) begin
                    bad++; $display("FAIL %s cmd_ready: got %b want 1", tag, cmd_ready);
                end
            end else begin
                if ({wd_ready, ram_wr, ram_addr} !== {1'b1, v, exp_addr}) begin
                    bad++;
                    $display("FAIL %s cycle%0d wd_ready/ram_wr/ram_addr: got %b/%b/%h want 1/%b/%h",
                             tag, c, wd_ready, ram_wr, ram_addr, v, exp_addr);
                end
                if (v) begin
                    total++;
                    if (ram_wdata !== wbuf[sent]) begin
                        bad++; $display("FAIL %s beat%0d ram_wdata: got %h want %h", tag, sent, ram_wdata, wbuf[sent]);
                    end
                    ref_mem[exp_addr] = wbuf[sent];
                    exp_addr = exp_addr + AW'(1);
                    sent++;
                end
            end
            c++;
        end
        total++;
        if (sent != n) begin
            bad++; $display("FAIL %s timeout: beats %0d want %0d", tag, sent, n);
        end
        @(negedge clk);
        cmd_valid = 1'b0; wd_valid = 1'b0;
        #1;
        total++;
        if ({cmd_ready, wd_ready, ram_wr, busy} !== 4'b1000) begin
            bad++;
            $display("FAIL %s end cmd_ready/wd_ready/ram_wr/busy: got %b%b%b%b want 1000",
                     tag, cmd_ready, wd_ready, ram_wr, busy);
        end
    endtask

    // Read burst; mode 0 ready held high with exact timing, 1 ready low in cycles 4..9, 2 random ready.
    task automatic run_read(input logic [AW-1:0] a, input logic [LW-1:0] l,
                            input int mode, input string tag);
        logic [DW:0] expq[$];
        logic [DW:0] e;
        logic [AW-1:0] issued;
        int n, got, c, held;
        n = int'(l) + 1; got = 0; c = 0;
        expq.delete();
        for (int i = 0; i < n; i++) expq.push_back({(i == n - 1), ref_mem[AW'(int'(a) + i)]});
        while (got < n && c < n + 80) begin
            @(negedge clk);
            cmd_valid = (c == 0); cmd_wr = 1'b0; cmd_addr = a; cmd_len = l; wd_valid = 1'b0;
            if (mode == 0) rd_ready = 1'b1;
            else if (mode == 1) rd_ready = !(c >= 4 && c <= 9);
            else rd_ready = 1'($urandom_range(0, 1));
            #1;
            total++;
            if (c == 0) begin
                if (cmd_ready !== 1'b1) begin
                    bad++; $display("FAIL %s cmd_ready: got %b want 1", tag, cmd_ready);
                end
            end else begin
                if (ram_wr !== 1'b0) begin
                    bad++; $display("FAIL %s cycle%0d ram_wr: got %b want 0", tag, c, ram_wr);
                end
                if (n < (1 << AW)) begin
                    issued = ram_addr - a;
                    held = int'(issued) - got;
                    total++;
                    if (held < 0 || held > HOLD_MAX) begin
                        bad++; $display("FAIL %s cycle%0d held beats: got %0d want 0..%0d", tag, c, held, HOLD_MAX);
                    end
                end
                if (mode == 0) begin
                    total++;
                    if (rd_valid !== 1'(c >= 3 && c <= n + 2)) begin
                        bad++; $display("FAIL %s cycle%0d rd_valid: got %b want %b", tag, c, rd_valid, (c >= 3 && c <= n + 2));
                    end
                end
            end
            if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
                total++;
                if (expq.size() == 0) begin
                    bad++; $display("FAIL %s extra beat: got %b_%h want none", tag, rd_last, rd_data);
                end else begin
                    e = expq.pop_front();
                    if ({rd_last, rd_data} !== e) begin
                        bad++; $display("FAIL %s beat%0d last/data: got %b/%h want %b/%h", tag, got, rd_last, rd_data, e[DW], e[DW-1:0]);
                    end
                end
                got++;
            end
            c++;
        end
        total++;
        if (got != n) begin
            bad++; $display("FAIL %s beat count: got %0d want %0d", tag, got, n);
        end
        @(negedge clk);
        cmd_valid = 1'b0; rd_ready = 1'b0;
        #1;
        total++;
        if ({busy, rd_valid, cmd_ready} !== 3'b001) begin
            bad++; $display("FAIL %s end busy/rd_valid/cmd_ready: got %b%b%b want 001", tag, busy, rd_valid, cmd_ready);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if ({cmd_ready, wd_ready, rd_valid, rd_last, ram_wr, busy, ram_addr, rd_data} !== '0) begin
            bad++;
            $display("FAIL reset_values: cmd_ready=%b wd_ready=%b rd_valid=%b rd_last=%b ram_wr=%b busy=%b ram_addr=%h rd_data=%h want all 0",
                     cmd_ready, wd_ready, rd_valid, rd_last, ram_wr, busy, ram_addr, rd_data);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({cmd_ready, busy} !== 2'b10) begin
            bad++; $display("FAIL reset_release cmd_ready/busy: got %b%b want 10", cmd_ready, busy);
        end
    endtask

    task automatic test_write_burst();
        for (int i = 0; i < 4; i++) wbuf[i] = DW'(8'hA0 + i);
        run_write(8'h10, 8'd3, 0, "write_burst");
    endtask

    task automatic test_read_burst();
        run_read(8'h10, 8'd3, 0, "read_burst");
    endtask

    task automatic test_write_stalls();
        fill_wbuf_random();
        run_write(8'h30, 8'd2, 1, "write_stalls");
        run_read(8'h30, 8'd2, 0, "write_stalls_rd");
    endtask

    task automatic test_wrap();
        fill_wbuf_random();
        run_write(8'hFE, 8'd3, 0, "wrap_wr");
        run_read(8'hFE, 8'd3, 0, "wrap_rd");
    endtask

    task automatic test_backpressure();
        fill_wbuf_random();
        run_write(8'h40, 8'd7, 0, "bp_wr");
        run_read(8'h40, 8'd7, 1, "bp_rd");
    endtask

    // Second read accepted while the first burst's beats still sit in the buffer.
    task automatic test_back_to_back();
        logic [DW:0] expq[$];
        logic [DW:0] e;
        int got, c;
        logic cmd2_done;
        got = 0; c = 0; cmd2_done = 1'b0;
        expq.delete();
        for (int i = 0; i < 2; i++) expq.push_back({(i == 1), ref_mem[AW'(8'h10 + i)]});
        for (int i = 0; i < 2; i++) expq.push_back({(i == 1), ref_mem[AW'(8'h12 + i)]});
        while (got < 4 && c < 100) begin
            @(negedge clk);
            cmd_wr = 1'b0; wd_valid = 1'b0; cmd_len = 8'd1;
            if (c == 0) begin cmd_valid = 1'b1; cmd_addr = 8'h10; end
            else if (c >= 3 && !cmd2_done) begin cmd_valid = 1'b1; cmd_addr = 8'h12; end
            else cmd_valid = 1'b0;
            rd_ready = (c >= 6) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            if (c == 0 || c == 3) begin
                total++;
                if ({cmd_ready, busy, rd_valid} !== ((c == 0) ? 3'b100 : 3'b111)) begin
                    bad++; $display("FAIL b2b cycle%0d cmd_ready/busy/rd_valid: got %b%b%b want %b",
                                    c, cmd_ready, busy, rd_valid, (c == 0) ? 3'b100 : 3'b111);
                end
            end
            if (c >= 3 && cmd_valid && cmd_ready) cmd2_done = 1'b1;
            if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
                total++;
                if (expq.size() == 0) begin
                    bad++; $display("FAIL b2b extra beat: got %h want none", rd_data);
                end else begin
                    e = expq.pop_front();
                    if ({rd_last, rd_data} !== e) begin
                        bad++; $display("FAIL b2b beat%0d last/data: got %b/%h want %b/%h", got, rd_last, rd_data, e[DW], e[DW-1:0]);
                    end
                end
                got++;
            end
            c++;
        end
        total++;
        if (got != 4 || !cmd2_done) begin
            bad++; $display("FAIL b2b completion: beats %0d cmd2 %b want 4 and 1", got, cmd2_done);
        end
        @(negedge clk);
        cmd_valid = 1'b0; rd_ready = 1'b0;
        #1;
        total++;
        if ({busy, cmd_ready} !== 2'b01) begin
            bad++; $display("FAIL b2b end busy/cmd_ready: got %b%b want 01", busy, cmd_ready);
        end
    endtask

    task automatic test_reset_mid_read();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            cmd_valid = (c == 0); cmd_wr = 1'b0; cmd_addr = 8'h10; cmd_len = 8'd3; rd_ready = 1'b1;
            if (c == 2) rst = 1'b1;
            #1;
            if (c == 1) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++; $display("FAIL rst_mid busy before reset: got %b want 1", busy);
                end
            end
            if (c == 2) begin
                total++;
                if ({rd_valid, busy, ram_wr, cmd_ready, wd_ready, ram_addr} !== '0) begin
                    bad++; $display("FAIL rst_mid during reset rd_valid/busy/ram_wr/cmd_ready/wd_ready/ram_addr: got %b%b%b%b%b/%h want 00000/00",
                                    rd_valid, busy, ram_wr, cmd_ready, wd_ready, ram_addr);
                end
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0; rst = 1'b0;
        #1;
        total++;
        if ({cmd_ready, busy, rd_valid} !== 3'b100) begin
            bad++; $display("FAIL rst_mid release cmd_ready/busy/rd_valid: got %b%b%b want 100", cmd_ready, busy, rd_valid);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            total++;
            if ({busy, rd_valid, ram_wr} !== 3'b000) begin
                bad++; $display("FAIL rst_mid discard cycle%0d busy/rd_valid/ram_wr: got %b%b%b want 000", c, busy, rd_valid, ram_wr);
            end
        end
        rd_ready = 1'b0;
        fill_wbuf_random();
        run_write(8'h20, 8'd3, 0, "post_rst_wr");
        run_read(8'h20, 8'd3, 0, "post_rst_rd");
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [LW-1:0] l;
        fill_wbuf_random();
        run_write(8'h00, 8'hFF, 2, "full_wr");
        run_read(8'h00, 8'hFF, 0, "full_rd");
        for (int k = 0; k < 6; k++) begin
            a = AW'($urandom);
            l = LW'($urandom_range(0, 12));
            fill_wbuf_random();
            run_write(a, l, 2, "rand_wr");
            run_read(a, l, 2, "rand_rd");
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_write_stalls();
        test_wrap();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
